// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA) with valid/ready flow control, flush and a sideband tag.
// Define SHIFT_ROTATE_EN to add ROL (4'b1000) and ROR (4'b1001).
module shift_unit_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [3:0]        alu_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result_shift,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LEVELS = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SRA  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } op_e;

    function automatic op_e decode_op(input logic [3:0] ctrl);
        op_e op;
        case (ctrl)
            4'b0101: op = OP_SLL;
            4'b0110: op = OP_SRL;
            4'b0111: op = OP_SRA;
`ifdef SHIFT_ROTATE_EN
            4'b1000: op = OP_ROL;
            4'b1001: op = OP_ROR;
`else
            4'b1000, 4'b1001: op = OP_NONE;
`endif
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic int lvl_lo(input int k);
        return (k * LEVELS) / STAGES;
    endfunction

    function automatic int lvl_hi(input int k);
        return ((k + 1) * LEVELS) / STAGES;
    endfunction

    // Applies the shift levels [lo, hi) selected by amt; each level moves by 2**level.
    function automatic logic [XLEN-1:0] shift_levels(
        input logic [XLEN-1:0]   val,
        input logic [LEVELS-1:0] amt,
        input op_e               op,
        input int                lo,
        input int                hi
    );
        logic [XLEN-1:0] r;
        int              n;
        r = val;
        for (int l = 0; l < LEVELS; l++) begin
            n = 32'sd1 << l;
            if (l >= lo && l < hi && amt[l]) begin
                case (op)
                    OP_SLL:  r = r << n;
                    OP_SRL:  r = r >> n;
                    OP_SRA:  r = $signed(r) >>> n;
`ifdef SHIFT_ROTATE_EN
                    OP_ROL:  r = (r << n) | (r >> (XLEN - n));
                    OP_ROR:  r = (r >> n) | (r << (XLEN - n));
`endif
                    default: r = r;
                endcase
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [XLEN-1:0]   data_q  [STAGES];
    logic [XLEN-1:0]   data_d  [STAGES];
    logic [LEVELS-1:0] shamt_q [STAGES];
    logic [LEVELS-1:0] shamt_d [STAGES];
    op_e               op_q    [STAGES];
    op_e               op_d    [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_d   [STAGES];

    logic [STAGES-1:0] stage_rdy_s;
    logic [STAGES-1:0] src_vld_s;
    logic [XLEN-1:0]   src_data_s  [STAGES];
    logic [LEVELS-1:0] src_shamt_s [STAGES];
    op_e               src_op_s    [STAGES];
    logic [TAG_W-1:0]  src_tag_s   [STAGES];
    op_e               in_op_s;
    logic              accept_s;
    logic              unused_rs2_s;
    logic              unused_tail_s;

    // A stage can take new content when it, or any stage downstream, is empty or the output drains.
    always_comb begin
        logic acc;
        acc         = out_ready;
        stage_rdy_s = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc            = acc | ~vld_q[k];
            stage_rdy_s[k] = acc;
        end
    end

    assign in_ready = stage_rdy_s[0] & ~flush;
    assign accept_s = in_valid & in_ready;
    assign in_op_s  = decode_op(alu_ctrl);

    // Per-stage source: the input port for stage 0, the previous stage register otherwise.
    always_comb begin
        src_vld_s      = '0;
        src_vld_s[0]   = accept_s;
        src_data_s[0]  = (in_op_s == OP_NONE) ? '0 : rs1;
        src_shamt_s[0] = rs2[LEVELS-1:0];
        src_op_s[0]    = in_op_s;
        src_tag_s[0]   = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            src_vld_s[k]   = vld_q[k-1];
            src_data_s[k]  = data_q[k-1];
            src_shamt_s[k] = shamt_q[k-1];
            src_op_s[k]    = op_q[k-1];
            src_tag_s[k]   = tag_q[k-1];
        end
    end

    // Next-state for every stage: flush kills, a ready stage loads its source, otherwise hold.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k]  = data_q[k];
            shamt_d[k] = shamt_q[k];
            op_d[k]    = op_q[k];
            tag_d[k]   = tag_q[k];
            if (flush) begin
                vld_d[k] = 1'b0;
            end else if (stage_rdy_s[k]) begin
                vld_d[k] = src_vld_s[k];
            end else begin
                vld_d[k] = vld_q[k];
            end
            // Payload only moves with a valid op, so the output holds its last result otherwise.
            if (!flush && stage_rdy_s[k] && src_vld_s[k]) begin
                data_d[k]  = shift_levels(src_data_s[k], src_shamt_s[k], src_op_s[k],
                                          lvl_lo(k), lvl_hi(k));
                shamt_d[k] = src_shamt_s[k];
                op_d[k]    = src_op_s[k];
                tag_d[k]   = src_tag_s[k];
            end else begin
                data_d[k]  = data_q[k];
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                op_q[k]    <= OP_NONE;
                tag_q[k]   <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= data_d[k];
                shamt_q[k] <= shamt_d[k];
                op_q[k]    <= op_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    assign out_valid     = vld_q[STAGES-1];
    assign result_shift  = data_q[STAGES-1];
    assign out_tag       = tag_q[STAGES-1];

    assign unused_rs2_s  = ^rs2[XLEN-1:LEVELS];
    assign unused_tail_s = ^{shamt_q[STAGES-1], op_q[STAGES-1]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe (XLEN=32, STAGES=2): directed table, sequences and random traffic.
module tb_shift_unit_pipe;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [3:0]       alu_ctrl;
    logic [4:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result_shift;
    logic [4:0]       out_tag;

    shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .alu_ctrl     (alu_ctrl),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_shift (result_shift),
        .out_tag      (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[10];
    int          checks   = 0;
    int          failures = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: shift amount is rs2 mod 32; rotates via a doubled word.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        int          sh;
        logic [63:0] w;
        logic [31:0] r;
        sh = int'(b % 32);
        w  = {a, a};
        r  = '0;
        case (c)
            4'b0101: r = a << sh;
            4'b0110: r = a >> sh;
            4'b0111: r = 32'($signed(a) >>> sh);
`ifdef SHIFT_ROTATE_EN
            4'b1000: begin w = w << sh; r = w[63:32]; end
            4'b1001: begin w = w >> sh; r = w[31:0];  end
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] rand_ctrl();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 4'b0101;
            2, 3:    return 4'b0110;
            4, 5:    return 4'b0111;
            6:       return 4'b1000;
            7:       return 4'b1001;
            8:       return 4'b0000;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic rand_op();
        rs1      = $urandom();
        rs2      = $urandom();
        alu_ctrl = rand_ctrl();
        in_tag   = 5'($urandom_range(0, 31));
    endtask

    // One clock: checks at the falling edge, scoreboard update, then returns 1 time unit after the rising edge.
    task automatic tick();
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        exp_rdy = !flush && (out_ready || (exp_q.size() < STAGES));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result_shift), 64'(prev_res));
            chk("hold_tag", 64'(out_tag), 64'(prev_tag));
        end
        hold_prev = out_valid && !out_ready && !flush;
        prev_res  = result_shift;
        prev_tag  = out_tag;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'(result_shift), 64'(e.res));
                    chk("tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_shift(rs1, rs2, alu_ctrl), in_tag});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; alu_ctrl = '0; in_tag = '0;

        vecs[0] = '{32'h0000_0001, 32'h0000_0023, 4'b0101, 5'd1,  32'h0000_0008};
        vecs[1] = '{32'h8000_0000, 32'h0000_001F, 4'b0110, 5'd2,  32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h0000_0004, 4'b0111, 5'd3,  32'hF800_0000};
        vecs[3] = '{32'hDEAD_BEEF, 32'h0000_0005, 4'b0000, 5'd4,  32'h0000_0000};
        vecs[4] = '{32'h8000_1234, 32'h0000_0020, 4'b0111, 5'd5,  32'h8000_1234};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_001F, 4'b0101, 5'd6,  32'h8000_0000};
        vecs[6] = '{32'h7FFF_FFFF, 32'h0000_001F, 4'b0111, 5'd7,  32'h0000_0000};
`ifdef SHIFT_ROTATE_EN
        vecs[7] = '{32'h8000_0001, 32'h0000_0001, 4'b1000, 5'd8,  32'h0000_0003};
        vecs[8] = '{32'h0000_0001, 32'h0000_0001, 4'b1001, 5'd9,  32'h8000_0000};
`else
        vecs[7] = '{32'h8000_0001, 32'h0000_0001, 4'b1000, 5'd8,  32'h0000_0000};
        vecs[8] = '{32'h0000_0001, 32'h0000_0001, 4'b1001, 5'd9,  32'h0000_0000};
`endif
        vecs[9] = '{32'h1234_5678, 32'h0000_0003, 4'b1111, 5'd10, 32'h0000_0000};

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result_shift), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table: latency of STAGES cycles, rs2 changes after accept must not matter
        foreach (vecs[i]) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; alu_ctrl = vecs[i].ctrl; in_tag = vecs[i].tag;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            rs2 = 32'hFFFF_FFFF;
            chk("lat_early", 64'(out_valid), 64'd0);
            tick();
            chk("lat_valid", 64'(out_valid), 64'd1);
            chk("vec_result", 64'(result_shift), 64'(vecs[i].exp));
            chk("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
            tick();
        end

        // Streaming: 8 back-to-back ops, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_op();
            in_valid = 1'b1;
            if (i >= STAGES) chk("stream_valid", 64'(out_valid), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            chk("stream_tail_valid", 64'(out_valid), 64'd1);
            tick();
        end
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: 5 cycles stalled with a continuous input stream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        chk("bp_held", 64'(exp_q.size()), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Flush with two ops in flight and a concurrent input op
        for (int i = 0; i < 2; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        flush  = 1'b1;
        in_tag = 5'h1F;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_stale", 64'(out_valid), 64'd0);
        end

        // Reset mid-operation
        for (int i = 0; i < 2; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(result_shift), 64'd0);
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_stale", 64'(out_valid), 64'd0);
            tick();
        end

        // Random traffic with stalls and occasional flush
        for (int i = 0; i < 400; i++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter for the execute stage. It is the multi-cycle successor of the single-cycle 32-bit shift unit.
- Accepts one shift op per cycle over a valid/ready handshake. Splits the log2(XLEN) shift levels across STAGES register stages.
- Carries a sideband tag (e.g. rd index) alongside each op. Supports backpressure and flush.

Parameters:
- XLEN, 32, data width; power of two, 8..128.
- STAGES, 2, register stages; 1..$clog2(XLEN).
- TAG_W, 5, width of the sideband tag carried with each op.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  op present on the input.
- in_ready  output  1  unit can accept an op this cycle.
- rs1  input  XLEN  operand to shift.
- rs2  input  XLEN  shift amount source; only the low $clog2(XLEN) bits are used.
- alu_ctrl  input  4  op select.
- in_tag  input  TAG_W  sideband, returned unmodified.
- out_valid  output  1  result present on the output.
- out_ready  input  1  consumer accepts the result.
- result_shift  output  XLEN  shifted result.
- out_tag  output  TAG_W  tag of the op on the output.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. On rst, every stage valid bit clears, result_shift=0, out_tag=0 and out_valid=0. in_ready=1 as soon as rst deasserts. Reset mid-operation discards all in-flight ops.
- shamt = rs2[$clog2(XLEN)-1:0]. It is captured on acceptance; later changes to rs2 do not affect the op.
- alu_ctrl decode:
  - 4'b0101 SLL: logical left shift, zero fill.
  - 4'b0110 SRL: logical right shift, zero fill.
  - 4'b0111 SRA: arithmetic right shift, filled with rs1[XLEN-1].
  - Any other code: the op flows through the pipe normally, with result_shift=0.
- shamt=0 returns rs1 unchanged for every valid op. shamt=XLEN-1 is the largest shift.
- Level split: LEVELS=$clog2(XLEN). Stage k (0..STAGES-1) applies shift levels [k*LEVELS/STAGES, (k+1)*LEVELS/STAGES), using integer division. Each stage registers its partial value, remaining op info and tag.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance, provided there is no backpressure.
- Handshake and flow:
  - An op is accepted when in_valid and in_ready are both high at a clock edge.
  - A transfer out occurs when out_valid and out_ready are both high.
  - A stage advances when the next stage is empty or is itself advancing. The last stage advances on out_ready.
  - in_ready = stage0 empty OR stage0 advancing, computed combinationally with no bubble.
  - Sustained throughput is 1 op/cycle while out_ready=1.
- Backpressure: while out_ready=0, result_shift, out_tag and out_valid hold stable. Upstream stages fill, then in_ready drops. No op is lost or duplicated.
- Flush: all valid bits clear at the next edge, so out_valid=0 the following cycle. An op presented in the same cycle as flush is not accepted; in_ready is forced to 0 while flush=1. Flush has priority over out_ready.
- Simultaneous accept and emit in the same cycle is legal; the pipe occupancy stays unchanged.
- Data path registers are not required to reset; valid bits and output registers are.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: adds two decodes.
  - 4'b1000 ROL: left rotate by shamt.
  - 4'b1001 ROR: right rotate by shamt.
  - Bits shifted out re-enter at the opposite end; the rotate amount is modulo XLEN.
  - Latency and handshake are identical to the shift ops.
- Not defined: 4'b1000 and 4'b1001 are unsupported codes and give result_shift=0. No rotate logic is synthesised.

Test Plan:
- Configuration for all scenarios: XLEN=32, STAGES=2.
- Reset mid-op: assert rst while 2 ops are in flight -> out_valid=0 and result_shift=0 immediately. in_ready=1 after release, and no stale op emerges.
- Shift ops, out_ready=1:
  - SLL rs1=0x0000_0001, rs2=0x0000_0023 (shamt=3) -> 0x0000_0008 with its tag, 2 cycles after accept.
  - SRL rs1=0x8000_0000, shamt=31 -> 0x0000_0001.
  - SRA rs1=0x8000_0000, shamt=4 -> 0xF800_0000.
  - Unsupported code 4'b0000 -> 0x0000_0000.
- Streaming: 8 back-to-back ops with random operands, out_ready=1 -> 8 results in order, one per cycle, each matching a reference model with matching tags.
- Backpressure: hold out_ready=0 for 5 cycles with a continuous input stream -> outputs stable. in_ready drops once 2 ops are held. After release, all ops drain in order with none lost.
- Flush: flush with 2 ops in flight and in_valid=1 -> in_ready=0 that cycle, out_valid=0 the next cycle, and the concurrent op is not accepted.
- SHIFT_ROTATE_EN defined:
  - ROL rs1=0x8000_0001, shamt=1 -> 0x0000_0003.
  - ROR rs1=0x0000_0001, shamt=1 -> 0x8000_0000.
- SHIFT_ROTATE_EN undefined: the same ROL/ROR ops return 0.
